// File: rtl/cnt_ctrl_pkg.sv
// Shared state encodings and default timing constants for the enable-counter control path.
// Also used by the counter testbench so both sides agree on DB_CYCLES/DIV.
package cnt_ctrl_pkg;

    typedef enum logic {
        ST_STOPPED = 1'b0,
        ST_RUNNING = 1'b1
    } ctrl_state_t;

    localparam int DEF_DB_CYCLES = 4;
    localparam int DEF_DIV       = 5;

    // Counter width for a modulo-n count; never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button qualifier: 2-flop synchronizer, stability counter, one-cycle press pulse.
// Latency: raw rise sampled at edge 0 gives press_pulse after edge DB_CYCLES+2; no backpressure.
module btn_debounce
    import cnt_ctrl_pkg::*;
#(
    parameter int DB_CYCLES = DEF_DB_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic press_pulse
);

    localparam int            CW      = cnt_w(DB_CYCLES);
    localparam logic [CW-1:0] DB_LAST = CW'(DB_CYCLES - 1);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic [CW-1:0] db_cnt_q, db_cnt_d;
    logic          db_level_q, db_level_d;
    logic          db_level_dly_q, db_level_dly_d;
    logic          press_q, press_d;

    always_comb begin
        sync1_d        = btn_raw;
        sync2_d        = sync1_q;
        db_level_d     = db_level_q;
        db_cnt_d       = '0;
        db_level_dly_d = db_level_q;
        press_d        = db_level_q & ~db_level_dly_q;

        // Any sample matching the accepted level restarts qualification.
        if (sync2_q != db_level_q) begin
            if (db_cnt_q == DB_LAST) begin
                db_level_d = sync2_q;
                db_cnt_d   = '0;
            end else begin
                db_cnt_d   = db_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q        <= 1'b0;
            sync2_q        <= 1'b0;
            db_cnt_q       <= '0;
            db_level_q     <= 1'b0;
            db_level_dly_q <= 1'b0;
            press_q        <= 1'b0;
        end else begin
            sync1_q        <= sync1_d;
            sync2_q        <= sync2_d;
            db_cnt_q       <= db_cnt_d;
            db_level_q     <= db_level_d;
            db_level_dly_q <= db_level_dly_d;
            press_q        <= press_d;
        end
    end

    assign press_pulse = press_q;

endmodule

// File: rtl/count_enable_ctrl.sv
// RUN/STOP control for the enable counter: debounced buttons, 2-state FSM, DIV-cycle tick prescaler.
// Latency: press pulse acts on the following edge; enable/running registered; no backpressure.
module count_enable_ctrl
    import cnt_ctrl_pkg::*;
#(
    parameter int DB_CYCLES = DEF_DB_CYCLES,
    parameter int DIV       = DEF_DIV
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_run,
    input  logic btn_step,
    output logic enable,
    output logic running,
    output logic run_pulse
);

    localparam int            DW       = cnt_w(DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

    logic          run_press;
    logic          step_press;

    ctrl_state_t   state_q, state_d;
    logic [DW-1:0] div_cnt_q, div_cnt_d;
    logic          enable_q, enable_d;

    btn_debounce #(
        .DB_CYCLES (DB_CYCLES)
    ) u_db_run (
        .clk         (clk),
        .rst_n       (reset),
        .btn_raw     (btn_run),
        .press_pulse (run_press)
    );

    btn_debounce #(
        .DB_CYCLES (DB_CYCLES)
    ) u_db_step (
        .clk         (clk),
        .rst_n       (reset),
        .btn_raw     (btn_step),
        .press_pulse (step_press)
    );

    // Run press has priority over both a step tick and a prescaler wrap.
    always_comb begin
        state_d   = state_q;
        div_cnt_d = div_cnt_q;
        enable_d  = 1'b0;

        case (state_q)
            ST_STOPPED: begin
                if (run_press) begin
                    state_d   = ST_RUNNING;
                    div_cnt_d = '0;
                end else if (step_press) begin
                    enable_d  = 1'b1;
                end
            end
            ST_RUNNING: begin
                if (run_press) begin
                    state_d   = ST_STOPPED;
                    div_cnt_d = '0;
                end else if (div_cnt_q == DIV_LAST) begin
                    div_cnt_d = '0;
                    enable_d  = 1'b1;
                end else begin
                    div_cnt_d = div_cnt_q + 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_STOPPED;
            div_cnt_q <= '0;
            enable_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_cnt_q <= div_cnt_d;
            enable_q  <= enable_d;
        end
    end

    assign enable    = enable_q;
    assign running   = (state_q == ST_RUNNING);
    assign run_pulse = run_press;

endmodule
